reg_file: RTL
=============

# reg_file

Architectural register file for the RV32I core, sitting at the receiving end of the MEM/WB writeback interface. Accepts one write per cycle from the MEM/WB stage register and serves two registered read ports to the ID stage, with same-cycle write-to-read bypass. It also keeps a per-register pending-write scoreboard: ID marks a destination when it issues, and writeback retires it. ID consumes the resulting busy flags to raise stalls.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers; index width 5.
- `CNT_W`, 2: width of each scoreboard counter; maximum in-flight writes per register is 3.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` upstream.
- `stall_state`  in  `Stall_size`  stall bus; bit 1 (ID stall) holds the read outputs.
- `modify_flag`  in  1  write enable from MEM/WB.
- `modify_address`  in  5  destination register index.
- `modify_data`  in  `Data_size` (32)  write data.
- `read1_flag`, `read2_flag`  in  1  read-port enables.
- `read1_address`, `read2_address`  in  5  source register indices.
- `read1_data`, `read2_data`  out  32  registered read results.
- `busy1`, `busy2`  out  1  combinational: the addressed source has a pending write not retiring this cycle.
- `issue_flag`  in  1  ID issued an instruction that writes `issue_address`.
- `issue_address`  in  5  destination being issued.
- `flush`  in  1  pipeline flush; clears the scoreboard.
- `sb_overflow`  out  1  sticky error: an issue arrived at a saturated counter.

## Operation
- Write: when `modify_flag`=1 and `modify_address`≠0, `regs[modify_address]` ← `modify_data` at the edge. Writes to x0 are dropped.
- Read: at an edge with `stall_state[1]`=0, `readN_data` ← value of the addressed register, or 0 if `readN_flag`=0 or the address is 0.
  - Bypass: if the same cycle has `modify_flag`=1 and `modify_address`=`readN_address`≠0, the captured value is `modify_data`.
  - With `stall_state[1]`=1, `readN_data` holds its value.
- Scoreboard: each register N≠0 has a CNT_W-bit counter `cnt[N]`.
  - Issue to N alone: increment.
  - Retire to N alone (`modify_flag` with `modify_address`=N): decrement.
  - Issue and retire to N in the same cycle: counter unchanged.
  - Decrement at 0 saturates at 0. This covers retirements of writes that were in flight when `flush` cleared the scoreboard.
  - Issue at 3 (no simultaneous retire): counter stays 3 and `sb_overflow` ← 1. `sb_overflow` stays 1 until reset.
  - Issue or retire to x0 is ignored; `cnt[0]` is constant 0.
- `flush`=1: all counters ← 0 at the edge. `flush` takes priority over a same-cycle issue and retire.
- Busy: `busyN` = `readN_flag` & (`readN_address`≠0) & (`cnt[addr]`≠0) & ¬(`modify_flag` & `modify_address`=addr & `cnt[addr]`=1). A final write retiring this cycle is satisfied by the bypass.
- Reset (`rst`=0, asynchronous): all `regs` = 0, all counters = 0, `read1_data` = `read2_data` = 0, `sb_overflow` = 0. `busy1`/`busy2` therefore read 0. Reset mid-operation discards pending scoreboard state immediately.

## Timing
- Write latency: 1 cycle. Data written at edge k is visible from the array at edge k+1; via the bypass it is visible at edge k itself.
- Read latency: 1 cycle. Address presented in cycle k gives data on `readN_data` after edge k.
- `busyN` depends on the current-cycle address, counters and write port, with no register stage. ID samples it in the same cycle it presents addresses.
- Scoreboard updates take effect at the edge. An issue in cycle k makes `busy` assert from cycle k+1.
- No backpressure toward MEM/WB: every asserted write is accepted.

## Structure
- `defines.v` gets `Reg_Address_size` (4:0), `Reg_num` (32) and `Stall_ID` (bit index 1) alongside the existing `Data_size` and `Stall_size`.
- Sub-module `reg_scoreboard` holds the counter array, issue/retire/flush logic, busy generation and `sb_overflow`.
- `reg_file` holds the storage array, read capture/bypass and the `reg_scoreboard` instance.

## Test plan
- Reset, then read x0..x31 on both ports → all data 0, busy 0. Write x0=0xDEADBEEF, then read x0 → 0.
- Write x5=0x12345678 while port 1 reads x5 in the same cycle → `read1_data`=0x12345678 after that edge. Read x5 next cycle → same value from the array.
- Hold `stall_state[1]`=1 for 3 cycles while changing addresses → `read1_data`/`read2_data` unchanged. Release → new values captured at the next edge.
- Issue x7 twice (`cnt`=2) → `busy1`=1 on reads of x7. First retire → still busy. Second retire cycle → `busy1`=0 in that cycle, `read1_data` gets the bypassed value. Simultaneous issue and retire to x7 → `cnt` unchanged.
- Issue x9 four times → `cnt`=3, `sb_overflow`=1 and it stays 1. Assert `flush` → all busy 0. A later retire to x9 → `cnt` stays 0.
- Assert `rst`=0 between clock edges with x3 pending and data loaded → outputs and counters read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared sizes and helpers for the RV32I architectural register file and its
// pending-write scoreboard.
//   Data_size        : width of a register / writeback datum
//   Stall_size       : width of the pipeline stall bus
//   Stall_ID         : stall-bus bit that freezes the ID stage (read outputs)
//   Reg_num          : number of architectural registers
//   Reg_Address_size : register index width
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int Data_size        = 32;
    localparam int Stall_size       = 6;
    localparam int Stall_ID         = 1;
    localparam int Reg_num          = 32;
    localparam int Reg_Address_size = 5;

    typedef logic [Data_size-1:0]        data_t;
    typedef logic [Reg_Address_size-1:0] reg_addr_t;

    // True when an enabled port targets register b, excluding x0
    // (x0 is never written, so it can never match a write or a pending slot).
    function automatic logic addr_hit(input logic flag,
                                      input reg_addr_t a,
                                      input reg_addr_t b);
        return flag && (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register count of in-flight writes. ID increments on issue, writeback
// decrements on retire; busy flags tell ID a source is not yet readable.
// Ports:
//   clk, rst                : clock, async active-low reset
//   i_flush                 : clear all counters (wins over issue/retire)
//   i_issue_flag/_address   : destination being issued by ID
//   i_retire_flag/_address  : write retiring from MEM/WB
//   i_readN_flag/_address   : ID source operands being checked
//   o_busyN                 : combinational hazard flag per read port
//   o_sb_overflow           : sticky, issue hit a saturated counter
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = Reg_num,
    parameter int CNT_W   = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  logic      i_issue_flag,
    input  reg_addr_t i_issue_address,
    input  logic      i_retire_flag,
    input  reg_addr_t i_retire_address,
    input  logic      i_read1_flag,
    input  reg_addr_t i_read1_address,
    input  logic      i_read2_flag,
    input  reg_addr_t i_read2_address,
    output logic      o_busy1,
    output logic      o_busy2,
    output logic      o_sb_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   r_cnt [REG_NUM];
    logic               r_sb_overflow;
    logic [REG_NUM-1:0] w_inc;
    logic [REG_NUM-1:0] w_dec;
    logic               w_overflow;
    logic [CNT_W-1:0]   w_cnt1;
    logic [CNT_W-1:0]   w_cnt2;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_inc[i] = i_issue_flag  && (i_issue_address  == reg_addr_t'(i));
            w_dec[i] = i_retire_flag && (i_retire_address == reg_addr_t'(i));
        end
    end

    // A flushed issue is discarded, so it cannot overflow either.
    assign w_overflow = addr_hit(i_issue_flag, i_issue_address, i_issue_address)
                        && !addr_hit(i_retire_flag, i_retire_address, i_issue_address)
                        && (r_cnt[i_issue_address] == CNT_MAX)
                        && !i_flush;

    // Entry 0 is only ever cleared, so it reads as a constant zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
            r_sb_overflow <= 1'b0;
        end else begin
            if (w_overflow) r_sb_overflow <= 1'b1;
            for (int i = 1; i < REG_NUM; i++) begin
                if (i_flush)
                    r_cnt[i] <= '0;
                else if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNT_MAX))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    assign w_cnt1 = r_cnt[i_read1_address];
    assign w_cnt2 = r_cnt[i_read2_address];

    // The last outstanding write retiring this cycle reaches ID via the bypass.
    assign o_busy1 = i_read1_flag && (i_read1_address != '0) && (w_cnt1 != '0)
                     && !(addr_hit(i_retire_flag, i_retire_address, i_read1_address)
                          && (w_cnt1 == CNT_ONE));
    assign o_busy2 = i_read2_flag && (i_read2_address != '0) && (w_cnt2 != '0)
                     && !(addr_hit(i_retire_flag, i_retire_address, i_read2_address)
                          && (w_cnt2 == CNT_ONE));

    assign o_sb_overflow = r_sb_overflow;

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// RV32I architectural register file: one MEM/WB write port, two registered
// ID read ports with same-cycle write bypass, plus the pending-write
// scoreboard ID uses to stall on outstanding destinations.
// Ports:
//   clk, rst                      : clock, async active-low reset
//   stall_state                   : stall bus, Stall_ID bit freezes read outputs
//   modify_flag/_address/_data    : writeback port (x0 writes dropped)
//   readN_flag/_address           : ID read request
//   readN_data                    : registered read result
//   busyN                         : combinational pending-write hazard
//   issue_flag/_address           : ID marks a destination in flight
//   flush                         : clear the scoreboard
//   sb_overflow                   : sticky scoreboard saturation error
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = Reg_num,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Stall_size-1:0] stall_state,
    input  logic                  modify_flag,
    input  reg_addr_t             modify_address,
    input  data_t                 modify_data,
    input  logic                  read1_flag,
    input  logic                  read2_flag,
    input  reg_addr_t             read1_address,
    input  reg_addr_t             read2_address,
    output data_t                 read1_data,
    output data_t                 read2_data,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  issue_flag,
    input  reg_addr_t             issue_address,
    input  logic                  flush,
    output logic                  sb_overflow
);

    data_t r_regs [REG_NUM];
    data_t r_read1;
    data_t r_read2;
    data_t w_rd1_next;
    data_t w_rd2_next;

    always_comb begin
        w_rd1_next = '0;
        if (read1_flag && (read1_address != '0))
            w_rd1_next = addr_hit(modify_flag, modify_address, read1_address)
                         ? modify_data : r_regs[read1_address];
    end

    always_comb begin
        w_rd2_next = '0;
        if (read2_flag && (read2_address != '0))
            w_rd2_next = addr_hit(modify_flag, modify_address, read2_address)
                         ? modify_data : r_regs[read2_address];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else if (modify_flag && (modify_address != '0)) begin
            r_regs[modify_address] <= modify_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read1 <= '0;
            r_read2 <= '0;
        end else if (!stall_state[Stall_ID]) begin
            r_read1 <= w_rd1_next;
            r_read2 <= w_rd2_next;
        end
    end

    assign read1_data = r_read1;
    assign read2_data = r_read2;

    reg_scoreboard #(
        .REG_NUM (REG_NUM),
        .CNT_W   (CNT_W)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (flush),
        .i_issue_flag     (issue_flag),
        .i_issue_address  (issue_address),
        .i_retire_flag    (modify_flag),
        .i_retire_address (modify_address),
        .i_read1_flag     (read1_flag),
        .i_read1_address  (read1_address),
        .i_read2_flag     (read2_flag),
        .i_read2_address  (read2_address),
        .o_busy1          (busy1),
        .o_busy2          (busy2),
        .o_sb_overflow    (sb_overflow)
    );

endmodule
